// File: rtl/lateral_inhibition_kwta.sv
// k-winner-take-all lateral inhibition for one STDP layer: latches up to K winners
// per gamma cycle, records the first winner and its spike time, then suppresses losers.
module lateral_inhibition_kwta #(
    parameter int unsigned NEURONS     = 16,
    parameter int unsigned LOG_NEURONS = 4,
    parameter int unsigned TIME_PERIOD = 8,
    parameter int unsigned LOG_TIME    = 3,
    parameter int unsigned K           = 1,
    parameter int unsigned TIE_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_gamma_start,
    input  logic                   i_step_valid,
    input  logic [LOG_TIME-1:0]    i_time_val,
    input  logic [NEURONS-1:0]     i_spike_volley,
    output logic [NEURONS-1:0]     o_winner_mask,
    output logic [NEURONS-1:0]     o_inhibit_mask,
    output logic [LOG_NEURONS:0]   o_winner_count,
    output logic [LOG_NEURONS:0]   o_winning_neuron,
    output logic [LOG_TIME-1:0]    o_win_time,
    output logic                   o_output_spike,
    output logic                   o_done
);

    localparam logic [LOG_NEURONS:0] NoWinner = '1;
    localparam logic [LOG_NEURONS:0] KCount   = (LOG_NEURONS+1)'(K);
    localparam logic [LOG_TIME-1:0]  LastStep = LOG_TIME'(TIME_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

    state_e                   r_state, w_state_next;
    logic [NEURONS-1:0]       r_winner_mask, r_inhibit_mask;
    logic [LOG_NEURONS:0]     r_count, r_winning;
    logic [LOG_TIME-1:0]      r_win_time;
    logic                     r_spike, r_done;
    logic [LOG_NEURONS-1:0]   r_ptr, r_last_idx;

    logic [NEURONS-1:0]       w_cand, w_grant;
    logic [LOG_NEURONS-1:0]   w_start, w_first_idx, w_last_idx, w_final_last, w_ptr_next;
    logic [LOG_NEURONS:0]     w_count_next;
    logic                     w_step, w_finish;
    int unsigned              w_idx, w_n, w_budget;

    // Priority grant: walk NEURONS positions from the start pointer, wrapping.
    always_comb begin
        w_grant     = '0;
        w_first_idx = '0;
        w_last_idx  = '0;
        w_n         = 0;
        w_idx       = 0;
        w_cand      = i_spike_volley & ~r_winner_mask;
        w_start     = (TIE_MODE == 1) ? r_ptr : '0;
        w_budget    = K - 32'(r_count);
        for (int i = 0; i < int'(NEURONS); i++) begin
            w_idx = 32'(w_start) + 32'(i);
            if (w_idx >= NEURONS) w_idx = w_idx - NEURONS;
            if (w_cand[w_idx[LOG_NEURONS-1:0]] && (w_n < w_budget)) begin
                w_grant[w_idx[LOG_NEURONS-1:0]] = 1'b1;
                if (w_n == 0) w_first_idx = LOG_NEURONS'(w_idx);
                w_last_idx = LOG_NEURONS'(w_idx);
                w_n        = w_n + 1;
            end
        end
    end

    assign w_count_next = r_count + (LOG_NEURONS+1)'(w_n);
    assign w_step       = (r_state == StCollect) && i_step_valid && !i_gamma_start;
    assign w_finish     = w_step && ((w_count_next == KCount) || (i_time_val == LastStep));
    assign w_final_last = (w_n != 0) ? w_last_idx : r_last_idx;
    assign w_ptr_next   = (32'(w_final_last) + 1 >= NEURONS) ? '0 : w_final_last + 1'b1;

    always_comb begin
        w_state_next = r_state;
        if (i_gamma_start) begin
            w_state_next = StCollect;
        end else if (w_finish) begin
            w_state_next = StHold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner_mask  <= '0;
            r_inhibit_mask <= '0;
            r_count        <= '0;
            r_winning      <= NoWinner;
            r_win_time     <= '0;
            r_spike        <= 1'b0;
            r_done         <= 1'b0;
            r_ptr          <= '0;
            r_last_idx     <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_gamma_start) begin
                r_winner_mask  <= '0;
                r_inhibit_mask <= '0;
                r_count        <= '0;
                r_winning      <= NoWinner;
                r_win_time     <= '0;
                r_spike        <= 1'b0;
            end else if (w_step) begin
                r_winner_mask <= r_winner_mask | w_grant;
                r_count       <= w_count_next;
                if (w_n != 0) r_last_idx <= w_last_idx;
                if (!r_spike && (w_n != 0)) begin
                    r_winning  <= {1'b0, w_first_idx};
                    r_win_time <= i_time_val;
                    r_spike    <= 1'b1;
                end
                if (w_finish) begin
                    r_done <= 1'b1;
                    if (w_count_next != '0) begin
                        r_inhibit_mask <= ~(r_winner_mask | w_grant);
                        if (TIE_MODE == 1) r_ptr <= w_ptr_next;
                    end
                end
            end
        end
    end

    assign o_winner_mask    = r_winner_mask;
    assign o_inhibit_mask   = r_inhibit_mask;
    assign o_winner_count   = r_count;
    assign o_winning_neuron = r_winning;
    assign o_win_time       = r_win_time;
    assign o_output_spike   = r_spike;
    assign o_done           = r_done;

endmodule

// File: tb/tb_lateral_inhibition_kwta.sv
// Directed bench for lateral_inhibition_kwta: three instances (K=1, K=3, rotating K=1)
// share one stimulus stream; each step checks the instance it targets.
module tb_lateral_inhibition_kwta;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gs = 1'b0;
    logic        sv = 1'b0;
    logic [2:0]  tv = '0;
    logic [15:0] vol = '0;

    logic [15:0] a_wm, a_im, b_wm, b_im, c_wm, c_im;
    logic [4:0]  a_cnt, a_win, b_cnt, b_win, c_cnt, c_win;
    logic [2:0]  a_wt, b_wt, c_wt;
    logic        a_sp, a_dn, b_sp, b_dn, c_sp, c_dn;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lateral_inhibition_kwta #(.K(1), .TIE_MODE(0)) u_k1 (
        .clk(clk), .rst_n(rst_n), .i_gamma_start(gs), .i_step_valid(sv), .i_time_val(tv),
        .i_spike_volley(vol), .o_winner_mask(a_wm), .o_inhibit_mask(a_im),
        .o_winner_count(a_cnt), .o_winning_neuron(a_win), .o_win_time(a_wt),
        .o_output_spike(a_sp), .o_done(a_dn));

    lateral_inhibition_kwta #(.K(3), .TIE_MODE(0)) u_k3 (
        .clk(clk), .rst_n(rst_n), .i_gamma_start(gs), .i_step_valid(sv), .i_time_val(tv),
        .i_spike_volley(vol), .o_winner_mask(b_wm), .o_inhibit_mask(b_im),
        .o_winner_count(b_cnt), .o_winning_neuron(b_win), .o_win_time(b_wt),
        .o_output_spike(b_sp), .o_done(b_dn));

    lateral_inhibition_kwta #(.K(1), .TIE_MODE(1)) u_rot (
        .clk(clk), .rst_n(rst_n), .i_gamma_start(gs), .i_step_valid(sv), .i_time_val(tv),
        .i_spike_volley(vol), .o_winner_mask(c_wm), .o_inhibit_mask(c_im),
        .o_winner_count(c_cnt), .o_winning_neuron(c_win), .o_win_time(c_wt),
        .o_output_spike(c_sp), .o_done(c_dn));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge; return just after the following posedge.
    task automatic apply(input logic g, input logic s, input logic [2:0] t, input logic [15:0] v);
        @(negedge clk);
        gs = g; sv = s; tv = t; vol = v;
        @(posedge clk);
        #1;
        gs = 1'b0; sv = 1'b0; tv = '0; vol = '0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_wmask", a_wm, 16'h0000);
        chk("rst_imask", a_im, 16'h0000);
        chk("rst_count", a_cnt, 5'd0);
        chk("rst_win",   a_win, 5'h1F);
        chk("rst_wtime", a_wt, 3'd0);
        chk("rst_spike", a_sp, 1'b0);
        chk("rst_done",  a_dn, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // K=1 lowest-index: t=2 volley 0x0014
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        chk("k1_start_done", a_dn, 1'b0);
        apply(1'b0, 1'b1, 3'd2, 16'h0014);
        chk("k1_win",   a_win, 5'd2);
        chk("k1_wtime", a_wt, 3'd2);
        chk("k1_wmask", a_wm, 16'h0004);
        chk("k1_imask", a_im, 16'hFFFB);
        chk("k1_count", a_cnt, 5'd1);
        chk("k1_spike", a_sp, 1'b1);
        chk("k1_done",  a_dn, 1'b1);
        apply(1'b0, 1'b0, 3'd0, 16'h0000);
        chk("k1_done_fall", a_dn, 1'b0);
        apply(1'b0, 1'b1, 3'd3, 16'h8000);
        chk("k1_hold_ignore", a_wm, 16'h0004);
        chk("k1_hold_win", a_win, 5'd2);

        // K=1, silent cycle: resolves on the t=7 step with no winner
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        chk("ns_clr_win", a_win, 5'h1F);
        chk("ns_clr_spike", a_sp, 1'b0);
        for (int t = 0; t < 7; t++) apply(1'b0, 1'b1, 3'(t), 16'h0000);
        chk("ns_t6_done", a_dn, 1'b0);
        apply(1'b0, 1'b1, 3'd7, 16'h0000);
        chk("ns_done",  a_dn, 1'b1);
        chk("ns_win",   a_win, 5'h1F);
        chk("ns_spike", a_sp, 1'b0);
        chk("ns_imask", a_im, 16'h0000);

        // K=3: t=1 0x0001, repeat spike on winner, t=4 0x00F0
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd1, 16'h0001);
        chk("k3_s1_count", b_cnt, 5'd1);
        chk("k3_s1_imask", b_im, 16'h0000);
        chk("k3_s1_done",  b_dn, 1'b0);
        apply(1'b0, 1'b1, 3'd2, 16'h0001);
        chk("k3_recount",  b_cnt, 5'd1);
        apply(1'b0, 1'b1, 3'd4, 16'h00F0);
        chk("k3_wmask", b_wm, 16'h0031);
        chk("k3_count", b_cnt, 5'd3);
        chk("k3_win",   b_win, 5'd0);
        chk("k3_wtime", b_wt, 3'd1);
        chk("k3_imask", b_im, 16'hFFCE);
        chk("k3_done",  b_dn, 1'b1);

        // Rotating priority: pointer advances past the last winner and wraps
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd0, 16'h0003);
        chk("rot_a_win", c_win, 5'd0);
        chk("rot_a_wmask", c_wm, 16'h0001);
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd0, 16'h0003);
        chk("rot_b_win", c_win, 5'd1);
        chk("rot_b_imask", c_im, 16'hFFFD);
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd0, 16'h0003);
        chk("rot_c_wrap", c_win, 5'd0);

        // Asynchronous reset mid-collect
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd1, 16'h0001);
        chk("mid_pre_count", b_cnt, 5'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_count", b_cnt, 5'd0);
        chk("mid_wmask", b_wm, 16'h0000);
        chk("mid_win",   b_win, 5'h1F);
        chk("mid_spike", b_sp, 1'b0);
        chk("mid_wtime", b_wt, 3'd0);
        #1 rst_n = 1'b1;
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd0, 16'h0002);
        chk("post_rst_win", b_win, 5'd1);
        chk("post_rst_count", b_cnt, 5'd1);

        // gamma_start beats a coincident volley
        apply(1'b1, 1'b1, 3'd0, 16'hFFFF);
        chk("gs_pri_count", b_cnt, 5'd0);
        chk("gs_pri_wmask", b_wm, 16'h0000);
        chk("gs_pri_done",  b_dn, 1'b0);
        apply(1'b0, 1'b1, 3'd0, 16'h0008);
        chk("gs_next_count", b_cnt, 5'd1);
        chk("gs_next_win",   b_win, 5'd3);
        chk("gs_next_wmask", b_wm, 16'h0008);

        // Count reaching K on the last step yields one done pulse
        apply(1'b1, 1'b0, 3'd0, 16'h0000);
        apply(1'b0, 1'b1, 3'd7, 16'h0100);
        chk("both_done", a_dn, 1'b1);
        chk("both_win",  a_win, 5'd8);
        apply(1'b0, 1'b0, 3'd0, 16'h0000);
        chk("both_single", a_dn, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
